// File: rtl/sr_ff_pkg.sv
// Shared types for the sr_ff flip-flop bank: illegal-input policy, s/r action
// decode and the next-state rule applied when s=r=1.
package sr_ff_pkg;

  typedef enum logic [1:0] {
    POL_HOLD   = 2'd0,
    POL_ZERO   = 2'd1,
    POL_ONE    = 2'd2,
    POL_TOGGLE = 2'd3
  } policy_e;

  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_RST     = 2'd1,
    ACT_SET     = 2'd2,
    ACT_ILLEGAL = 2'd3
  } sr_action_e;

  function automatic sr_action_e sr_decode(logic s, logic r);
    sr_action_e act;
    case ({s, r})
      2'b01:   act = ACT_RST;
      2'b10:   act = ACT_SET;
      2'b11:   act = ACT_ILLEGAL;
      default: act = ACT_HOLD;
    endcase
    return act;
  endfunction

  function automatic logic apply_policy(policy_e pol, logic q);
    logic nq;
    case (pol)
      POL_ZERO:   nq = 1'b0;
      POL_ONE:    nq = 1'b1;
      POL_TOGGLE: nq = ~q;
      default:    nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_ff_if.sv
// Data bus of the sr_ff bank: per-bit set/reset requests and the q/qbar state.
// Carries the sticky illegal flag only when SR_FF_ILLEGAL_FLAG_EN is defined.
interface sr_ff_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
`ifdef SR_FF_ILLEGAL_FLAG_EN
  logic             illegal;
`endif

  modport master (
    output s, r,
`ifdef SR_FF_ILLEGAL_FLAG_EN
    input  illegal,
`endif
    input  q, qbar
  );

  modport slave (
    input  s, r,
`ifdef SR_FF_ILLEGAL_FLAG_EN
    output illegal,
`endif
    output q, qbar
  );
endinterface

// File: rtl/sr_ff_cell.sv
// Single SR storage bit with clr > preset > s/r priority; flags s=r=1 on
// edges where the s/r table is actually in control.
module sr_ff_cell
  import sr_ff_pkg::*;
#(
  parameter int ILLEGAL_POLICY = 0
) (
  input  logic clk,
  input  logic clr,
  input  logic preset,
  input  logic s,
  input  logic r,
  output logic q,
  output logic illegal_strobe
);

  localparam policy_e POL = policy_e'(ILLEGAL_POLICY[1:0]);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 1'b0;
    end else if (preset) begin
      q <= 1'b1;
    end else begin
      case (sr_decode(s, r))
        ACT_RST:     q <= 1'b0;
        ACT_SET:     q <= 1'b1;
        ACT_ILLEGAL: q <= apply_policy(POL, q);
        default:     q <= q;
      endcase
    end
  end

  assign illegal_strobe = ~clr & ~preset & s & r;

endmodule

// File: rtl/sr_ff.sv
// WIDTH-bit bank of independent SR flip-flops sharing clk, clr and preset.
// Define SR_FF_ILLEGAL_FLAG_EN to add the sticky illegal flag on the bus.
module sr_ff
  import sr_ff_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int ILLEGAL_POLICY = 0
) (
  input  logic   clk,
  input  logic   clr,
  input  logic   preset,
  sr_ff_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("sr_ff: WIDTH must be in 1..64");
  end
  if (ILLEGAL_POLICY < 0 || ILLEGAL_POLICY > 3) begin : g_bad_policy
    $error("sr_ff: ILLEGAL_POLICY must be in 0..3");
  end

  logic [WIDTH-1:0] q_bits;
  logic [WIDTH-1:0] strobe;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell #(
      .ILLEGAL_POLICY(ILLEGAL_POLICY)
    ) u_cell (
      .clk           (clk),
      .clr           (clr),
      .preset        (preset),
      .s             (bus.s[i]),
      .r             (bus.r[i]),
      .q             (q_bits[i]),
      .illegal_strobe(strobe[i])
    );
  end

  // qbar is pure inversion of q so the pair can never disagree
  assign bus.q    = q_bits;
  assign bus.qbar = ~q_bits;

`ifdef SR_FF_ILLEGAL_FLAG_EN
  logic illegal_q;

  // sticky until clr; preset deliberately leaves it alone
  always_ff @(posedge clk) begin
    if (clr) begin
      illegal_q <= 1'b0;
    end else if (|strobe) begin
      illegal_q <= 1'b1;
    end
  end

  assign bus.illegal = illegal_q;
`else
  logic unused_strobe;
  assign unused_strobe = |strobe;
`endif

endmodule

// File: tb/tb_sr_ff.sv
// Self-checking bench for sr_ff: one WIDTH=1 bank plus four WIDTH=4 banks,
// one per illegal policy, all checked every cycle against a behavioural model.
module tb_sr_ff;

  logic clk = 1'b0;
  logic clr;
  logic preset;
  logic [3:0] s_in;
  logic [3:0] r_in;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sr_ff_if #(.WIDTH(1)) if_w1 ();
  sr_ff_if #(.WIDTH(4)) if_p0 ();
  sr_ff_if #(.WIDTH(4)) if_p1 ();
  sr_ff_if #(.WIDTH(4)) if_p2 ();
  sr_ff_if #(.WIDTH(4)) if_p3 ();

  sr_ff #(.WIDTH(1), .ILLEGAL_POLICY(0)) u_w1 (.clk(clk), .clr(clr), .preset(preset), .bus(if_w1.slave));
  sr_ff #(.WIDTH(4), .ILLEGAL_POLICY(0)) u_p0 (.clk(clk), .clr(clr), .preset(preset), .bus(if_p0.slave));
  sr_ff #(.WIDTH(4), .ILLEGAL_POLICY(1)) u_p1 (.clk(clk), .clr(clr), .preset(preset), .bus(if_p1.slave));
  sr_ff #(.WIDTH(4), .ILLEGAL_POLICY(2)) u_p2 (.clk(clk), .clr(clr), .preset(preset), .bus(if_p2.slave));
  sr_ff #(.WIDTH(4), .ILLEGAL_POLICY(3)) u_p3 (.clk(clk), .clr(clr), .preset(preset), .bus(if_p3.slave));

  always_comb begin
    if_w1.s = s_in[0];
    if_w1.r = r_in[0];
    if_p0.s = s_in; if_p0.r = r_in;
    if_p1.s = s_in; if_p1.r = r_in;
    if_p2.s = s_in; if_p2.r = r_in;
    if_p3.s = s_in; if_p3.r = r_in;
  end

  // Reference: each bit follows the SR truth table; s=r=1 bits take the policy value.
  function automatic logic [3:0] model_next(int pol, logic [3:0] q, logic [3:0] s, logic [3:0] r,
                                            logic c, logic p);
    logic [3:0] ill;
    logic [3:0] pv;
    if (c) return 4'h0;
    if (p) return 4'hF;
    ill = s & r;
    case (pol)
      0:       pv = q;
      1:       pv = 4'h0;
      2:       pv = 4'hF;
      default: pv = ~q;
    endcase
    return (q & ~s & ~r) | (s & ~r) | (ill & pv);
  endfunction

  logic [3:0] m_q [4];
  logic       m_w1;
  logic       m_valid = 1'b0;
  logic       m_ill = 1'b0;

  always @(posedge clk) begin
    logic [3:0] tmp;
    for (int p = 0; p < 4; p++) m_q[p] <= model_next(p, m_q[p], s_in, r_in, clr, preset);
    tmp = model_next(0, {3'b000, m_w1}, s_in, r_in, clr, preset);
    m_w1 <= tmp[0];
    if (clr || preset) m_valid <= 1'b1;
    if (clr) m_ill <= 1'b0;
    else if (!preset && |(s_in & r_in)) m_ill <= 1'b1;
  end

  task automatic cmp(string name, logic [3:0] act, logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  logic [3:0] dq [4];
  logic [3:0] dqb [4];
  always_comb begin
    dq[0] = if_p0.q; dqb[0] = if_p0.qbar;
    dq[1] = if_p1.q; dqb[1] = if_p1.qbar;
    dq[2] = if_p2.q; dqb[2] = if_p2.qbar;
    dq[3] = if_p3.q; dqb[3] = if_p3.qbar;
  end

  // Per-cycle comparison once the state is defined (after the first clr/preset edge).
  always @(negedge clk) begin
    if (m_valid) begin
      cmp("w1_q", {3'b000, if_w1.q}, {3'b000, m_w1});
      cmp("w1_qbar", {3'b000, if_w1.qbar}, {3'b000, ~m_w1});
      for (int p = 0; p < 4; p++) begin
        cmp($sformatf("p%0d_q", p), dq[p], m_q[p]);
        cmp($sformatf("p%0d_qbar", p), dqb[p], ~m_q[p]);
      end
`ifdef SR_FF_ILLEGAL_FLAG_EN
      cmp("p0_illegal", {3'b000, if_p0.illegal}, {3'b000, m_ill});
`endif
    end
  end

  // Drive at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic apply(logic c, logic p, logic [3:0] s, logic [3:0] r);
    clr = c; preset = p; s_in = s; r_in = r;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0; preset = 1'b0; s_in = '0; r_in = '0;
    @(negedge clk);

    // clr beats preset and set
    apply(1, 1, 4'hF, 4'h0);
    apply(1, 1, 4'hF, 4'h0);
    cmp("lit_reset_q", {3'b000, if_w1.q}, 4'h0);
    cmp("lit_reset_qbar", {3'b000, if_w1.qbar}, 4'h1);

    apply(0, 1, 4'h0, 4'hF);
    cmp("lit_preset_q", {3'b000, if_w1.q}, 4'h1);
    cmp("lit_preset_qbar", {3'b000, if_w1.qbar}, 4'h0);
    apply(0, 0, 4'h0, 4'h0);
    cmp("lit_preset_hold", {3'b000, if_w1.q}, 4'h1);

    // truth table from q=0, default policy holds on 11
    apply(1, 0, 4'h0, 4'h0);
    apply(0, 0, 4'h0, 4'h0); apply(0, 0, 4'h0, 4'h0);
    cmp("lit_tt_00", {3'b000, if_w1.q}, 4'h0);
    apply(0, 0, 4'h0, 4'h1); apply(0, 0, 4'h0, 4'h1);
    cmp("lit_tt_01", {3'b000, if_w1.q}, 4'h0);
    apply(0, 0, 4'h1, 4'h0); apply(0, 0, 4'h1, 4'h0);
    cmp("lit_tt_10", {3'b000, if_w1.q}, 4'h1);
    apply(0, 0, 4'h1, 4'h1); apply(0, 0, 4'h1, 4'h1);
    cmp("lit_tt_11", {3'b000, if_w1.q}, 4'h1);

    // illegal policies from q=0101
    apply(1, 0, 4'h0, 4'h0);
    apply(0, 0, 4'b0101, 4'h0);
    apply(0, 0, 4'hF, 4'hF);
    cmp("lit_pol0", if_p0.q, 4'b0101);
    cmp("lit_pol1", if_p1.q, 4'b0000);
    cmp("lit_pol2", if_p2.q, 4'b1111);
    cmp("lit_pol3", if_p3.q, 4'b1010);
`ifdef SR_FF_ILLEGAL_FLAG_EN
    cmp("lit_flag_set", {3'b000, if_p0.illegal}, 4'h1);
`endif
    apply(0, 0, 4'hF, 4'hF);
    cmp("lit_pol3_again", if_p3.q, 4'b0101);

    // per-bit independence
    apply(1, 0, 4'h0, 4'h0);
    apply(0, 0, 4'b1010, 4'b0001);
    cmp("lit_indep_a", if_p0.q, 4'b1010);
    apply(0, 0, 4'b0000, 4'b0010);
    cmp("lit_indep_b", if_p0.q, 4'b1000);

`ifdef SR_FF_ILLEGAL_FLAG_EN
    apply(0, 0, 4'h1, 4'h1);
    cmp("lit_flag_edge", {3'b000, if_p0.illegal}, 4'h1);
    apply(0, 1, 4'h0, 4'h0);
    cmp("lit_flag_thru_preset", {3'b000, if_p0.illegal}, 4'h1);
    apply(1, 0, 4'h0, 4'h0);
    cmp("lit_flag_clr", {3'b000, if_p0.illegal}, 4'h0);
    cmp("lit_flag_clr_q", if_p0.q, 4'h0);
`endif

    // randomized traffic, rare clr/preset, frequent illegal bits
    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(15) == 0), ($urandom_range(15) == 0),
            4'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
